// File: rtl/uart_tx_engine_if.sv
// Host-side handshake and framing bundle for the UART transmit engine.
// The master drives the request and frame settings; the engine drives the line and status.
interface uart_tx_engine_if;
  logic [18:0] baud_count;
  logic [7:0]  tx_data;
  logic        eight;
  logic        pen;
  logic        ohel;
  logic        load;
  logic        tx;
  logic        tx_ready;
  logic        tx_done;

  modport master (
    output baud_count, tx_data, eight, pen, ohel, load,
    input  tx, tx_ready, tx_done
  );

  modport slave (
    input  baud_count, tx_data, eight, pen, ohel, load,
    output tx, tx_ready, tx_done
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, 7/8 data bits LSB first, optional parity, one stop bit.
// Frame settings and bit period are captured on load so mid-frame input changes are ignored.
module uart_tx_engine (
  input  logic              clk,
  input  logic              reset,
  uart_tx_engine_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [18:0] timer;
  logic [18:0] cap_baud;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        cap_eight;
  logic        cap_pen;
  logic        parity_bit;
  logic        tx_reg;
  logic        tx_next;
  logic        done_reg;
  logic        done_next;
  logic        bit_end;
  logic        last_data;
  logic        accept;

  assign bit_end   = (timer == 19'd1);
  assign last_data = (bit_idx == (cap_eight ? 3'd7 : 3'd6));
  assign accept    = (state == IDLE) && bus.load;

  // Next-state and next line value; tx is registered, so the bit that follows a boundary is chosen here.
  always_comb begin
    state_next = state;
    tx_next    = 1'b1;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) begin
          state_next = DATA;
          tx_next    = shreg[0];
        end
      end
      DATA: begin
        tx_next = shreg[0];
        if (bit_end) begin
          if (last_data) begin
            state_next = cap_pen ? PARITY : STOP;
            tx_next    = cap_pen ? parity_bit : 1'b1;
          end else begin
            tx_next = shreg[1];
          end
        end
      end
      PARITY: begin
        tx_next = parity_bit;
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      tx_reg     <= 1'b1;
      done_reg   <= 1'b0;
      timer      <= 19'd0;
      cap_baud   <= 19'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'd0;
      cap_eight  <= 1'b0;
      cap_pen    <= 1'b0;
      parity_bit <= 1'b0;
    end else begin
      state    <= state_next;
      tx_reg   <= tx_next;
      done_reg <= done_next;
      if (accept) begin
        // A zero period would never reach the end-of-bit value, so treat it as one cycle.
        cap_baud   <= (bus.baud_count == 19'd0) ? 19'd1 : bus.baud_count;
        timer      <= (bus.baud_count == 19'd0) ? 19'd1 : bus.baud_count;
        shreg      <= bus.tx_data;
        cap_eight  <= bus.eight;
        cap_pen    <= bus.pen;
        parity_bit <= (^(bus.tx_data & {bus.eight, 7'h7F})) ^ bus.ohel;
        bit_idx    <= 3'd0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          timer <= cap_baud;
          if (state == DATA) begin
            bit_idx <= bit_idx + 3'd1;
            shreg   <= shreg >> 1;
          end
        end else begin
          timer <= timer - 19'd1;
        end
      end
    end
  end

  assign bus.tx       = tx_reg;
  assign bus.tx_ready = (state == IDLE);
  assign bus.tx_done  = done_reg;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a frame-level reference model checks every cycle,
// and directed plus randomized frames are decoded at mid-bit and compared against expected frames.
module tb_uart_tx_engine;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  uart_tx_engine_if bus_if ();

  uart_tx_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected frame as a bit vector indexed by bit position on the line; unused high bits read as idle 1.
  function automatic logic [10:0] frameVec(input logic [7:0] d, input logic e, input logic p, input logic o);
    logic [10:0] v;
    int          n;
    logic        par;
    v    = '1;
    v[0] = 1'b0;
    n    = 1;
    par  = 1'b0;
    for (int i = 0; i < (e ? 8 : 7); i++) begin
      v[n] = d[i];
      par  = par ^ d[i];
      n++;
    end
    if (p) begin
      v[n] = o ? ~par : par;
      n++;
    end
    v[n] = 1'b1;
    return v;
  endfunction

  function automatic int frameLen(input logic e, input logic p);
    return 2 + (e ? 8 : 7) + (p ? 1 : 0);
  endfunction

  // Reference model: a frame occupies N*B cycles after the accepting edge, bit k = frame[t / B].
  logic        exp_tx;
  logic        exp_ready;
  logic        exp_done;
  logic        m_busy;
  int          m_t;
  int          m_b;
  int          m_n;
  logic [10:0] m_vec;

  initial m_busy = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_busy   = 1'b0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (m_busy) begin
        m_t++;
        if (m_t == m_n * m_b) begin
          m_busy   = 1'b0;
          exp_done = 1'b1;
        end
      end else if (bus_if.load) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_b    = (bus_if.baud_count == 19'd0) ? 1 : int'(bus_if.baud_count);
        m_vec  = frameVec(bus_if.tx_data, bus_if.eight, bus_if.pen, bus_if.ohel);
        m_n    = frameLen(bus_if.eight, bus_if.pen);
      end
    end
    exp_tx    = m_busy ? m_vec[m_t / m_b] : 1'b1;
    exp_ready = ~m_busy;
    #1;
    checkOutput("cyc_tx", bus_if.tx, exp_tx);
    checkOutput("cyc_ready", bus_if.tx_ready, exp_ready);
    checkOutput("cyc_done", bus_if.tx_done, exp_done);
  end

  logic [10:0] seen_vec;
  int          seen_n;
  int          done_at;

  // Issues one load and decodes the line at mid-bit until tx_done; optionally pokes inputs mid-frame.
  task automatic applyStimulus(input logic [18:0] baud, input logic [7:0] data, input logic e,
                               input logic p, input logic o, input int poke_m, input logic hold);
    int b;
    int limit;
    @(negedge clk);
    bus_if.baud_count = baud;
    bus_if.tx_data    = data;
    bus_if.eight      = e;
    bus_if.pen        = p;
    bus_if.ohel       = o;
    bus_if.load       = 1'b1;
    b        = (baud == 19'd0) ? 1 : int'(baud);
    limit    = 12 * b + 4;
    seen_vec = '1;
    seen_n   = 0;
    done_at  = 0;
    for (int m = 1; m <= limit; m++) begin
      @(negedge clk);
      if (m == 1 && !hold) bus_if.load = 1'b0;
      if (poke_m != 0 && m == poke_m) begin
        bus_if.load       = 1'b1;
        bus_if.tx_data    = ~data;
        bus_if.baud_count = 19'd4;
      end
      if (poke_m != 0 && m == poke_m + 1) bus_if.load = 1'b0;
      if (bus_if.tx_done) begin
        done_at = m;
        break;
      end
      if ((m - 1) % b == b / 2 && seen_n < 11) begin
        seen_vec[seen_n] = bus_if.tx;
        seen_n++;
      end
    end
    checkOutput("frame_done_seen", done_at != 0, 1'b1);
  endtask

  task automatic checkFrame(input logic [18:0] baud, input logic [7:0] data, input logic e,
                            input logic p, input logic o);
    int b;
    b = (baud == 19'd0) ? 1 : int'(baud);
    checkOutput("frame_bits", seen_vec, frameVec(data, e, p, o));
    checkOutput("frame_len", seen_n, frameLen(e, p));
    checkOutput("frame_latency", done_at, frameLen(e, p) * b + 1);
  endtask

  task automatic waitDone(input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus_if.tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("wait_done", seen, 1'b1);
  endtask

  task automatic countDone(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus_if.tx_done) cnt++;
    end
  endtask

  initial begin
    logic [7:0]  d;
    logic [18:0] b;
    logic        e;
    logic        p;
    logic        o;
    int          cnt;
    int          poke;

    checks            = 0;
    failures          = 0;
    reset             = 1'b0;
    bus_if.load       = 1'b1;
    bus_if.baud_count = 19'd4;
    bus_if.tx_data    = 8'h00;
    bus_if.eight      = 1'b1;
    bus_if.pen        = 1'b0;
    bus_if.ohel       = 1'b0;

    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_tx", bus_if.tx, 1'b1);
      checkOutput("rst_ready", bus_if.tx_ready, 1'b1);
      checkOutput("rst_done", bus_if.tx_done, 1'b0);
    end
    reset       = 1'b1;
    bus_if.load = 1'b0;

    applyStimulus(19'd4, 8'hA5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("a5_bits", seen_vec, 11'h74A);
    checkOutput("a5_latency", done_at, 41);
    countDone(12, cnt);
    checkOutput("a5_single_done", cnt, 0);

    applyStimulus(19'd2, 8'hFF, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    checkOutput("odd7_bits", seen_vec, 11'h6FE);
    checkOutput("odd7_latency", done_at, 21);
    applyStimulus(19'd2, 8'hFF, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("even7_bits", seen_vec, 11'h7FE);

    applyStimulus(19'd0, 8'h3C, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("zero_baud_latency", done_at, 11);
    checkFrame(19'd0, 8'h3C, 1'b1, 1'b0, 1'b0);

    applyStimulus(19'd3, 8'h5A, 1'b1, 1'b1, 1'b0, 7, 1'b0);
    checkFrame(19'd3, 8'h5A, 1'b1, 1'b1, 1'b0);
    countDone(20, cnt);
    checkOutput("ignored_load_no_frame", cnt, 0);

    applyStimulus(19'd3, 8'hC3, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    checkFrame(19'd3, 8'hC3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("b2b_start", bus_if.tx, 1'b0);
    checkOutput("b2b_busy", bus_if.tx_ready, 1'b0);
    bus_if.load = 1'b0;
    waitDone(40);

    applyStimulus(19'd868, 8'h96, 1'b1, 1'b0, 1'b0, 1000, 1'b0);
    checkFrame(19'd868, 8'h96, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    bus_if.baud_count = 19'd4;
    bus_if.tx_data    = 8'hE7;
    bus_if.load       = 1'b1;
    @(negedge clk);
    bus_if.load = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("midrst_tx", bus_if.tx, 1'b1);
    checkOutput("midrst_ready", bus_if.tx_ready, 1'b1);
    countDone(50, cnt);
    checkOutput("midrst_no_done", cnt, 0);
    applyStimulus(19'd4, 8'h4D, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    checkFrame(19'd4, 8'h4D, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 16; i++) begin
      d    = 8'($urandom);
      b    = 19'($urandom_range(0, 6));
      e    = 1'($urandom);
      p    = 1'($urandom);
      o    = 1'($urandom);
      poke = ($urandom_range(0, 1) == 1)
             ? int'($urandom_range(2, frameLen(e, p) * ((b == 19'd0) ? 1 : int'(b)))) : 0;
      applyStimulus(b, d, e, p, o, poke, 1'b0);
      checkFrame(b, d, e, p, o);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
